// File: rtl/pc_call_ctrl.sv
// Program counter with call/return control driving an external 8-bit return stack.
// Latency: PC/DEPTH/flags update on the next rising edge; STK_PUSH/STK_POP/STK_VALUE are same-cycle combinational.
// Backpressure: STALL holds all state and suppresses stack strobes; no other flow control.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   STALL/JUMP/CALL/RET action requests, decoded with priority STALL > RET > CALL > JUMP > increment
//   TARGET              jump/call destination
//   STK_DATA            return-stack read data, valid while STK_POP is high
//   PC                  registered program counter
//   STK_PUSH/STK_POP    return-stack strobes (never both high)
//   STK_VALUE           return address to push, always PC + INSTR_BYTES
//   DEPTH               number of return addresses currently stacked
//   OVERFLOW/UNDERFLOW  sticky fault flags, cleared only by rst
//
// Optional feature: define PC_CALL_CTRL_FAULT_HALT_EN to freeze the controller in
// HALT on the first overflow/underflow. The default build never leaves RUN.
module pc_call_ctrl #(
  parameter int    UUID        = 0,
  parameter string NAME        = "",
  parameter int    INSTR_BYTES = 4,
  parameter int    STACK_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       STALL,
  input  logic       JUMP,
  input  logic       CALL,
  input  logic       RET,
  input  logic [7:0] TARGET,
  input  logic [7:0] STK_DATA,
  output logic [7:0] PC,
  output logic       STK_PUSH,
  output logic       STK_POP,
  output logic [7:0] STK_VALUE,
  output logic [5:0] DEPTH,
  output logic       OVERFLOW,
  output logic       UNDERFLOW
);

  // Elaboration-time range checks on the configuration.
  if (INSTR_BYTES < 1 || INSTR_BYTES > 255) begin : g_bad_instr_bytes
    $error("pc_call_ctrl: INSTR_BYTES must be in 1..255");
  end
  if (STACK_DEPTH < 1 || STACK_DEPTH > 63) begin : g_bad_stack_depth
    $error("pc_call_ctrl: STACK_DEPTH must be in 1..63");
  end
  if (UUID < 0) begin : g_bad_uuid
    $error("pc_call_ctrl: UUID must be non-negative");
  end

  localparam logic [7:0] PC_INC    = 8'(INSTR_BYTES);
  localparam logic [5:0] MAX_DEPTH = 6'(STACK_DEPTH);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0] pc_q;
  logic [5:0] depth_q;
  logic       ovf_q;
  logic       unf_q;
  logic [0:0] state_q;

  // ---------------------------------------------------------------------------
  // Action decode
  // ---------------------------------------------------------------------------
  logic       active;      // cycle may change architectural state
  logic       act_ret;
  logic       act_call;
  logic       act_jump;
  logic       stk_empty;
  logic       stk_full;
  logic       do_pop;
  logic       do_push;
  logic       ret_fault;
  logic       call_fault;
  logic       fault_hold;  // fault cycle freezes PC instead of incrementing
  logic [7:0] pc_inc;
  logic [7:0] pc_next;
  logic [5:0] depth_next;
  logic [0:0] state_next;

  // Reset and HALT both mask every action so that no strobe can leak out
  // in a cycle whose effects are about to be discarded or are frozen.
  assign active = !rst && (state_q == S_RUN) && !STALL;

  assign act_ret  = active && RET;
  assign act_call = active && !RET && CALL;
  assign act_jump = active && !RET && !CALL && JUMP;

  assign stk_empty = (depth_q == 6'd0);
  assign stk_full  = (depth_q >= MAX_DEPTH);

  assign do_pop     = act_ret && !stk_empty;
  assign do_push    = act_call && !stk_full;
  assign ret_fault  = act_ret && stk_empty;
  assign call_fault = act_call && stk_full;

  assign pc_inc = pc_q + PC_INC;

`ifdef PC_CALL_CTRL_FAULT_HALT_EN
  // The faulting cycle is the first frozen cycle: PC stays where the bad
  // CALL/RET was issued so software can see the faulting address.
  assign fault_hold = ret_fault || call_fault;
`else
  assign fault_hold = 1'b0;
`endif

  always_comb begin
    pc_next = pc_q;
    if (!active || fault_hold) begin
      pc_next = pc_q;
    end else if (do_pop) begin
      pc_next = STK_DATA;
    end else if (do_push || act_jump) begin
      pc_next = TARGET;
    end else begin
      // Plain increment, also used for CALL/RET that fault without halting.
      pc_next = pc_inc;
    end
  end

  always_comb begin
    depth_next = depth_q;
    if (do_push) begin
      depth_next = depth_q + 6'd1;
    end else if (do_pop) begin
      depth_next = depth_q - 6'd1;
    end
  end

  always_comb begin
    state_next = state_q;
`ifdef PC_CALL_CTRL_FAULT_HALT_EN
    if (state_q == S_RUN && (ret_fault || call_fault)) begin
      state_next = S_HALT;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 8'h00;
      depth_q <= 6'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      state_q <= S_RUN;
    end else begin
      pc_q    <= pc_next;
      depth_q <= depth_next;
      ovf_q   <= ovf_q || call_fault;
      unf_q   <= unf_q || ret_fault;
      state_q <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign PC        = pc_q;
  assign DEPTH     = depth_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
  assign STK_PUSH  = do_push;
  assign STK_POP   = do_pop;
  assign STK_VALUE = pc_inc;

endmodule

// File: tb/tb_pc_call_ctrl.sv
// Scoreboard bench for pc_call_ctrl (default build, INSTR_BYTES=4, STACK_DEPTH=32).
// Driver applies one input vector per cycle and queues the outputs expected during that cycle.
// Monitor pops and compares on every falling edge while expectations are pending.
module tb_pc_call_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       STALL, JUMP, CALL, RET;
  logic [7:0] TARGET, STK_DATA;
  logic [7:0] PC, STK_VALUE;
  logic       STK_PUSH, STK_POP;
  logic [5:0] DEPTH;
  logic       OVERFLOW, UNDERFLOW;

  always #5 clk = ~clk;

  pc_call_ctrl #(
    .UUID(0), .NAME("dut"), .INSTR_BYTES(4), .STACK_DEPTH(32)
  ) dut (
    .clk(clk), .rst(rst), .STALL(STALL), .JUMP(JUMP), .CALL(CALL), .RET(RET),
    .TARGET(TARGET), .STK_DATA(STK_DATA), .PC(PC), .STK_PUSH(STK_PUSH),
    .STK_POP(STK_POP), .STK_VALUE(STK_VALUE), .DEPTH(DEPTH),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  typedef struct packed {
    logic [7:0] pc;
    logic       push;
    logic       pop;
    logic [5:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every output against the queued expectation.
  exp_t       m_e;
  logic [7:0] m_val;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_val = m_e.pc + 8'd4;
      chk("pc",        {24'd0, PC},        {24'd0, m_e.pc});
      chk("stk_push",  {31'd0, STK_PUSH},  {31'd0, m_e.push});
      chk("stk_pop",   {31'd0, STK_POP},   {31'd0, m_e.pop});
      chk("stk_value", {24'd0, STK_VALUE}, {24'd0, m_val});
      chk("depth",     {26'd0, DEPTH},     {26'd0, m_e.depth});
      chk("overflow",  {31'd0, OVERFLOW},  {31'd0, m_e.ovf});
      chk("underflow", {31'd0, UNDERFLOW}, {31'd0, m_e.unf});
    end
  end

  // Driver: apply inputs for one cycle and queue the outputs expected in it.
  task automatic step(input logic r, input logic st, input logic j, input logic c,
                      input logic rt, input logic [7:0] tgt, input logic [7:0] sd,
                      input logic [7:0] e_pc, input logic e_push, input logic e_pop,
                      input logic [5:0] e_depth, input logic e_ovf, input logic e_unf);
    rst = r; STALL = st; JUMP = j; CALL = c; RET = rt; TARGET = tgt; STK_DATA = sd;
    exp_q.push_back('{pc: e_pc, push: e_push, pop: e_pop, depth: e_depth, ovf: e_ovf, unf: e_unf});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; STALL = 1'b0; JUMP = 1'b0; CALL = 1'b0; RET = 1'b0;
    TARGET = 8'h00; STK_DATA = 8'h00;
    @(posedge clk);
    #1;

    //   rst st j c rt  tgt    sd     pc  push pop depth ovf unf
    // Reset held with CALL and RET requested: strobes must stay low.
    step(1, 0, 0, 1, 1, 8'h40, 8'h00, 8'h00, 0, 0, 6'd0, 0, 0);
    // Free-running increment.
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 6'd0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 0, 0, 6'd0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h08, 0, 0, 6'd0, 0, 0);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h0C, 0, 0, 6'd0, 0, 0);
    // CALL 0x40 from 0x10 pushes 0x14, then RET pops it back.
    step(0, 0, 0, 1, 0, 8'h40, 8'h00, 8'h10, 1, 0, 6'd0, 0, 0);
    step(0, 0, 0, 0, 1, 8'h00, 8'h14, 8'h40, 0, 1, 6'd1, 0, 0);
    // JUMP to 0x20, no stack traffic.
    step(0, 0, 1, 0, 0, 8'h20, 8'h00, 8'h14, 0, 0, 6'd0, 0, 0);
    // RET on empty stack: no pop, underflow, PC increments.
    step(0, 0, 0, 0, 1, 8'h00, 8'hAA, 8'h20, 0, 0, 6'd0, 0, 0);
    step(0, 0, 0, 1, 0, 8'h80, 8'h00, 8'h24, 1, 0, 6'd0, 0, 1);
    // CALL+RET+JUMP at depth 1: RET wins.
    step(0, 0, 1, 1, 1, 8'h90, 8'h28, 8'h80, 0, 1, 6'd1, 0, 1);
    // CALL under STALL: PC held, no strobes.
    step(0, 1, 0, 1, 0, 8'h90, 8'h00, 8'h28, 0, 0, 6'd0, 0, 1);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h28, 0, 0, 6'd0, 0, 1);

    // Five CALLs, then reset during a sixth CALL at depth 5.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 8'h50 + 8'(i), 8'h00,
           (i == 0) ? 8'h2C : 8'h4F + 8'(i), 1, 0, 6'(i), 0, 1);
    end
    step(1, 0, 0, 1, 0, 8'h60, 8'h00, 8'h54, 0, 0, 6'd5, 0, 1);

    // Fill the 32-entry stack, then one CALL too many.
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 1, 0, 8'h50 + 8'(i), 8'h00,
           (i == 0) ? 8'h00 : 8'h4F + 8'(i), 1, 0, 6'(i), 0, 0);
    end
    step(0, 0, 0, 1, 0, 8'h99, 8'h00, 8'h6F, 0, 0, 6'd32, 0, 0);
    step(0, 0, 0, 0, 1, 8'h00, 8'h77, 8'h73, 0, 1, 6'd32, 1, 0);
    // PC wrap: 0xFC + 4 -> 0x00.
    step(0, 0, 1, 0, 0, 8'hFC, 8'h00, 8'h77, 0, 0, 6'd31, 1, 0);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFC, 0, 0, 6'd31, 1, 0);
    step(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 6'd31, 1, 0);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
